// File: rtl/ram8_bank.sv
// Eight-word register bank: one-hot write decode, registered read port and a
// sequenced clear-all sweep that locks out writes while it runs.

module ram8_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (ld)  q <= d;
    end
endmodule

module ram8_bank #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clr_start,
    output logic             busy,
    output logic             clr_done
);
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              cnt;
    logic                    wr_fire;
    logic [7:0]              load;
    logic [7:0]              clr_vec;
    logic [7:0][WIDTH-1:0]   mem;

    assign wr_fire = wr_valid & wr_ready;
    assign load    = {7'b0, wr_fire} << wr_addr;
    assign clr_vec = {7'b0, state == CLEAR} << cnt;

    ram8_word #(.WIDTH(WIDTH)) u_word [7:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (load),
        .clr   (clr_vec),
        .d     ({8{wr_data}}),
        .q     (mem)
    );

    // Counter idles at 0, so the 7->0 wrap lines up with the return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state == CLEAR) ? cnt + 3'd1 : 3'd0;
            clr_done <= (state == CLEAR) && (cnt == 3'd7);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_start)     state_nxt = CLEAR;
            CLEAR:   if (cnt == 3'd7)   state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state == IDLE);
        busy     = (state == CLEAR);
    end

    // Reads see pre-edge contents, so a same-cycle write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: tb/tb_ram8_bank.sv
// Bench for ram8_bank: vector table plus hand-driven sweep sequences, with
// expected read data queued at issue and compared when rd_valid appears.

module tb_ram8_bank;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [2:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             clr_start;
    logic             busy;
    logic             clr_done;

    ram8_bank #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             wv;
        logic [2:0]       wa;
        logic [WIDTH-1:0] wd;
        logic             re;
        logic [2:0]       ra;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t             tbl[$];
    logic [WIDTH-1:0] sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_valid  = 1'b0;
        wr_addr   = 3'd0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr   = 3'd0;
        clr_start = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [WIDTH-1:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        sb.push_back(e);
    endtask

    function automatic vec_t mk(input logic wv, input logic [2:0] wa, input logic [WIDTH-1:0] wd,
                                input logic re, input logic [2:0] ra, input logic [WIDTH-1:0] exp);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.exp = exp;
        return v;
    endfunction

    // Scoreboard: every rd_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got rd_valid=1 data=%0h, want no read", rd_data);
            end else begin
                chk("rd_data", {16'h0, rd_data}, {16'h0, sb.pop_front()});
            end
        end
    end

    // Mode 0: plain sweep with reads mid-sweep and an ignored clr_start.
    // Mode 1: write+clr_start together, then a write held across the sweep.
    task automatic sweep(input int mode);
        int busy_cnt = 0, done_cnt = 0, done_at = 0, ready_bad = 0, acc = 0;
        idle_in();
        clr_start = 1'b1;
        if (mode == 1) begin
            wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'h7777;
        end
        tick();
        idle_in();
        for (int c = 1; c <= 14; c++) begin
            if (busy) busy_cnt++;
            if (busy && wr_ready) ready_bad++;
            if (clr_done) begin done_cnt++; done_at = c; end
            if (mode == 0) begin
                rd_en = 1'b0; clr_start = 1'b0;
                if (c == 2) rd(3'd3, 16'h00A3);
                if (c == 3) begin rd(3'd0, 16'h0000); clr_start = 1'b1; end
                if (c == 4) rd(3'd7, 16'h00A7);
            end else begin
                rd_en = 1'b0;
                if (c == 1) begin wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF; end
                if (c == 2) rd(3'd2, 16'h7777);
                if (acc == 0 && wr_valid && wr_ready) acc = c;
            end
            tick();
            if (acc != 0) wr_valid = 1'b0;
        end
        idle_in();
        chk($sformatf("busy_cycles_m%0d", mode), busy_cnt, 8);
        chk($sformatf("wr_ready_in_clear_m%0d", mode), ready_bad, 0);
        chk($sformatf("clr_done_pulses_m%0d", mode), done_cnt, 1);
        chk($sformatf("clr_done_cycle_m%0d", mode), done_at, 9);
        if (mode == 1) chk("held_write_accept_cycle", acc, 9);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        rst_n = 1'b0;
        idle_in();

        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 1, 3'(i), 16'h0));
        tbl.push_back(mk(1, 3'd5, 16'h1234, 1, 3'd5, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 1, 3'd5, 16'h1234));
        tbl.push_back(mk(0, 0, 0, 1, 3'd4, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 1, 3'd6, 16'h0000));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 3'(i), 16'(16'h00A0 + i), 0, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 1, 3'(i), 16'(16'h00A0 + i)));

        #1;
        chk("rst_rd_data", {16'h0, rd_data}, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_wr_ready", wr_ready, 1);
        tick(); tick();
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            wr_valid = tbl[k].wv; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
            rd_en = tbl[k].re; rd_addr = tbl[k].ra;
            if (tbl[k].re) sb.push_back(tbl[k].exp);
            tick();
        end
        idle_in();
        tick();

        sweep(0);
        for (int i = 0; i < 8; i++) begin rd(3'(i), 16'h0); tick(); end
        idle_in();
        tick();

        sweep(1);
        rd(3'd2, 16'hBEEF); tick();
        rd(3'd3, 16'h0000); tick();
        idle_in();
        tick();

        // Reset in the 4th sweep cycle must abort without a clr_done pulse.
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'h1100 + i); tick();
        end
        idle_in();
        clr_start = 1'b1; tick();
        clr_start = 1'b0; tick(); tick(); tick();
        chk("busy_before_abort", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_clr_done", clr_done, 0);
        chk("abort_rd_data", {16'h0, rd_data}, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_wr_ready", wr_ready, 1);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 16'h0);
            tick();
            if (clr_done || busy) dn++;
        end
        idle_in();
        tick(); tick();
        chk("abort_no_done_or_busy", dn, 0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
